// File: rtl/prince_mask_pkg.sv
// Shared constants and types for the masked PRINCE S-box pipeline controller.
package prince_mask_pkg;

  localparam int unsigned RND_W  = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned HALF_W = 16;

  // Field offsets inside one 16-bit layer half; layer B repeats them above HALF_W.
  localparam int unsigned A_R1_LO = 0;
  localparam int unsigned A_R1_HI = 5;
  localparam int unsigned A_R2_LO = 6;
  localparam int unsigned A_R2_HI = 11;
  localparam int unsigned A_KL_LO = 12;
  localparam int unsigned A_KL_HI = 13;
  localparam int unsigned A_MN_LO = 14;
  localparam int unsigned A_MN_HI = 15;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    FLUSH
  } state_t;

endpackage

// File: rtl/rnd_fifo2.sv
// Two-entry randomness word FIFO with occupancy count and synchronous clear.
module rnd_fifo2 #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic [1:0]   o_cnt
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_cnt;

  // Cleared words are zeroed so discarded randomness never lingers in storage.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) r_rd_ptr <= ~r_rd_ptr;
      if (i_push && !i_pop)      r_cnt <= r_cnt + 2'd1;
      else if (i_pop && !i_push) r_cnt <= r_cnt - 2'd1;
    end
  end

  assign o_head = r_mem[r_rd_ptr];
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/prince_sbox_sched.sv
// Sequencer for the 4-stage masked PRINCE S-box: valid pipe, global stall,
// per-nibble randomness delivery and usage statistics.
module prince_sbox_sched #(
  parameter int unsigned RND_W = prince_mask_pkg::RND_W,
  parameter int unsigned CNT_W = prince_mask_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             rnd_valid,
  input  logic [RND_W-1:0] rnd_data,
  output logic             rnd_ready,
  output logic [3:0]       stage_en,
  output logic [15:0]      rnd_a,
  output logic [15:0]      rnd_b,
  output logic [CNT_W-1:0] words_used,
  output logic [CNT_W-1:0] starve_cnt
);

  import prince_mask_pkg::*;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [4:1]         r_v;
  logic [HALF_W-1:0]  r_rb1;
  logic [HALF_W-1:0]  r_rb2;
  logic               w_adv;
  logic               w_fire;
  logic               w_push;
  logic [RND_W-1:0]   w_head;
  logic [1:0]         w_fifo_cnt;

  assign w_adv     = !(r_v[4] && !out_ready);
  assign w_fire    = stage_en[0];
  assign w_push    = rnd_valid && rnd_ready;
  assign out_valid = r_v[4];

  rnd_fifo2 #(.W(RND_W)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (flush),
    .i_push (w_push),
    .i_din  (rnd_data),
    .i_pop  (w_fire),
    .o_head (w_head),
    .o_cnt  (w_fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL:    if (w_fifo_cnt == 2'd2) w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      FLUSH:   w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
    if (flush) w_state_nxt = FLUSH;
  end

  // flush outranks both the accept and the PRNG push in its cycle.
  always_comb begin
    in_ready  = 1'b0;
    rnd_ready = 1'b0;
    stage_en  = '0;
    if (!rst) begin
      in_ready  = (r_state == RUN) && w_adv && (w_fifo_cnt != 2'd0) && !flush;
      rnd_ready = (w_fifo_cnt < 2'd2) && (r_state != FLUSH) && !flush;
      stage_en  = {w_adv && r_v[3], w_adv && r_v[2], w_adv && r_v[1],
                   w_adv && in_valid && in_ready};
    end
  end

  // Layer-B half rides r_rb1 -> r_rb2 -> rnd_b alongside the nibble to reach S3.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_v   <= '0;
      rnd_a <= '0;
      r_rb1 <= '0;
      r_rb2 <= '0;
      rnd_b <= '0;
    end else begin
      if (w_adv) r_v <= {r_v[3:1], w_fire};
      if (stage_en[0]) begin
        rnd_a <= w_head[HALF_W-1:0];
        r_rb1 <= w_head[2*HALF_W-1:HALF_W];
      end
      if (stage_en[1]) r_rb2 <= r_rb1;
      if (stage_en[2]) rnd_b <= r_rb2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      words_used <= '0;
      starve_cnt <= '0;
    end else begin
      if (w_fire && (words_used != '1)) words_used <= words_used + 1'b1;
      if ((r_state == RUN) && in_valid && (w_fifo_cnt == 2'd0) && (starve_cnt != '1))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: doc/prince_sbox_sched.md
# prince_sbox_sched

Controller for the 4-stage, first-order masked PRINCE S-box datapath built from the coordinate-function instances. It sequences the stage registers with valid/ready flow control and stall handling. It delivers one fresh randomness word per nibble, split between the two nonlinear layers, and never reuses a word. It sits between the cipher round controller (nibble producer/consumer) and the PRNG.

## Interface
Parameters:
- RND_W, 32: bits per randomness word; [15:0] feeds layer A (r1, r2, kl, mn), [31:16] feeds layer B.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  single-cycle request to abort all in-flight nibbles.
- in_valid  in  1  producer has a masked nibble on the datapath input.
- in_ready  out  1  nibble accepted when in_valid && in_ready.
- out_valid  out  1  stage-4 register holds a valid result.
- out_ready  in  1  consumer accepts the result.
- rnd_valid  in  1  PRNG word available.
- rnd_data  in  RND_W  PRNG word.
- rnd_ready  out  1  controller accepts the PRNG word.
- stage_en  out  4  load enable for datapath stage registers S1..S4.
- rnd_a  out  16  layer-A randomness, aligned with S1 contents.
- rnd_b  out  16  layer-B randomness, aligned with S3 contents.
- words_used  out  CNT_W  saturating count of consumed PRNG words.
- starve_cnt  out  CNT_W  saturating count of cycles with in_valid high and the FIFO empty in RUN.

## Operation
- Datapath mapping:
  - S1 captures the input shares.
  - Layer A computes from S1 with rnd_a into S2.
  - The linear layer maps S2 into S3.
  - Layer B computes from S3 with rnd_b into S4.
  - S4 drives the output.
- Valid bits v[1..4] track S1..S4. out_valid = v[4].
- adv = !(v[4] && !out_ready). Stall is global and pipeline-wide. Bubbles are not collapsed.
- fire_in = in_valid && in_ready. in_ready = (state==RUN) && adv && (fifo_cnt != 0). fifo_cnt is registered.
- Stage enables:
  - stage_en[0] = adv && fire_in.
  - stage_en[i] = adv && v[i] for i = 1..3.
  - Masking hygiene: registers load only when the incoming stage is valid, so stale share combinations are never recombined.
- Randomness FIFO:
  - 2 entries. rnd_ready = (fifo_cnt < 2) && (state != FLUSH).
  - Push on rnd_valid && rnd_ready. Pop on fire_in. Simultaneous push and pop keeps the count unchanged.
- On fire_in:
  - rnd_a register loads head[15:0].
  - The rnd_b pipe (2 registers) loads head[31:16] and travels with the nibble. It advances on stage_en[1] and stage_en[2].
  - words_used increments.
- rnd_a and rnd_b hold their values while stalled. They are never cleared except by reset or flush.
- State machine:
  - FILL: in_ready = 0. Go to RUN when fifo_cnt == 2.
  - RUN: normal flow. flush goes to FLUSH.
  - FLUSH: lasts one cycle. v[1..4] clear, FIFO empties with its words discarded, rnd_a and rnd_b zero. Then go to FILL.
- flush has priority over fire_in and push in the same cycle. A nibble offered in that cycle is not accepted.
- starve_cnt increments in RUN when in_valid && fifo_cnt == 0.
- Both counters saturate at all-ones.
- Reset values:
  - state = FILL.
  - v = 0, so out_valid = 0.
  - in_ready = 0, rnd_ready = 0 during the reset cycle, stage_en = 0.
  - rnd_a = 0, rnd_b = 0, fifo_cnt = 0, words_used = 0, starve_cnt = 0.
- Reset mid-operation discards all in-flight data. There is no partial output.

## Timing
- Latency: nibble accepted at cycle t gives out_valid at t+4 with no stall.
- Throughput: 1 nibble per cycle when out_ready and the PRNG are sustained at 1 word per cycle.
- Randomness usage: each word is used exactly once. Layer-A half is used at t+1 and layer-B half at t+3, relative to acceptance.
- Stalls:
  - A stall (out_valid && !out_ready) freezes all stages, rnd_a and rnd_b in the same cycle.
  - A stall also freezes in_ready (in_ready = 0).
  - FIFO pushes continue during a stall.
- After reset or flush, in_ready is first high 2 cycles after the second PRNG word is offered, assuming rnd_valid is held high.
- All outputs are registered except in_ready, rnd_ready and stage_en, which are combinational from registered state and out_ready/in_valid.

## Structure
- Package prince_mask_pkg holds:
  - RND_W.
  - Layer field offsets: A_R1 [5:0], A_R2 [11:6], A_KL [13:12], A_MN [15:14], and the same layout in the B half.
  - State enum {FILL, RUN, FLUSH}.
  - CNT_W.
- Sub-module rnd_fifo2: 2-entry FIFO with count output and synchronous clear. Counters and the valid pipe stay inline.

## Test plan
- Reset, then rnd_valid held with words W0=0x11112222 and W1=0x33334444, and in_valid high: in_ready rises 2 cycles after W1 is offered. The first nibble gives rnd_a=0x2222 at t+1, rnd_b=0x1111 at t+3, and out_valid at t+4.
- 8 back-to-back nibbles with out_ready=1 and rnd_valid=1: out_valid high for 8 consecutive cycles starting at t+4, and words_used=8.
- out_ready held low for 3 cycles with 4 nibbles in flight: stage_en=0000, and rnd_a, rnd_b and out_valid hold. Nothing is lost or duplicated, and output order is preserved.
- rnd_valid dropped with in_valid high in RUN: in_ready=0 once the FIFO drains, and starve_cnt counts exactly the blocked cycles (e.g. 5).
- flush asserted with 3 nibbles in flight and in_valid high: the next cycle has v=0 and fifo_cnt=0, the nibble is not accepted, and the state returns to FILL. No old randomness reappears on rnd_a or rnd_b.
- words_used preset near all-ones by running 2^CNT_W accepts: the counter saturates at 0xFFFF and does not wrap.
